// File: rtl/mi_arbiter_rr_if.sv
// MI bus bundle; N > 1 carries one request slice per master, read data is shared.
// The arbiter uses the slave modport on its RX side and the master modport on its TX side.
interface mi_arbiter_rr_if #(
  parameter int N          = 1,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int META_WIDTH = 2
);
  logic [N*DATA_WIDTH-1:0]   dwr;
  logic [N*META_WIDTH-1:0]   mwr;
  logic [N*ADDR_WIDTH-1:0]   addr;
  logic [N*DATA_WIDTH/8-1:0] be;
  logic [N-1:0]              rd;
  logic [N-1:0]              wr;
  logic [N-1:0]              ardy;
  logic [DATA_WIDTH-1:0]     drd;
  logic [N-1:0]              drdy;

  modport master (output dwr, mwr, addr, be, rd, wr, input ardy, drd, drdy);
  modport slave  (input dwr, mwr, addr, be, rd, wr, output ardy, drd, drdy);
endinterface

// File: rtl/mi_arbiter_rr.sv
// Round-robin arbiter sharing one MI slave port among MASTERS requesters.
// Read responses are steered back in issue order through a small ID FIFO.
module mi_arbiter_rr #(
  parameter int MASTERS         = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int META_WIDTH      = 2,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  mi_arbiter_rr_if.slave  rx,
  mi_arbiter_rr_if.master tx
);
  localparam int GW = $clog2(MASTERS);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   id_mem_q [MAX_OUTSTANDING];
  logic [GW-1:0]   id_mem_d [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;

  logic [MASTERS-1:0] req_s, ardy_s, drdy_s;
  logic [GW-1:0]      next_grant_s, head_s;
  logic               found_s, busy_s, full_s, empty_s, blocked_s;
  logic               tx_rd_s, tx_wr_s, accept_s, push_s, pop_s;

  // First requester strictly after ptr, scanning cyclically; ptr itself is checked last.
  function automatic logic [GW:0] rr_pick(input logic [MASTERS-1:0] req, input logic [GW-1:0] ptr);
    logic [GW:0]   res;
    logic [GW-1:0] cand;
    res = {1'b0, ptr};
    for (int k = 1; k <= MASTERS; k++) begin
      cand = GW'((int'(ptr) + k) % MASTERS);
      if (!res[GW] && req[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign req_s = rx.rd | rx.wr;
  assign {found_s, next_grant_s} = rr_pick(req_s, ptr_q);

  assign busy_s    = (state_q == ST_BUSY);
  assign full_s    = (cnt_q == (PW+1)'(MAX_OUTSTANDING));
  assign empty_s   = (cnt_q == {(PW+1){1'b0}});
  assign blocked_s = busy_s && rx.rd[grant_q] && full_s;
  assign tx_rd_s   = busy_s && rx.rd[grant_q] && !full_s;
  assign tx_wr_s   = busy_s && rx.wr[grant_q];
  assign accept_s  = tx.ardy && (tx_rd_s || tx_wr_s);
  assign push_s    = accept_s && tx_rd_s;
  assign pop_s     = tx.drdy && !empty_s;
  assign head_s    = id_mem_q[rd_ptr_q];

  assign tx.dwr  = rx.dwr[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign tx.mwr  = rx.mwr[grant_q*META_WIDTH +: META_WIDTH];
  assign tx.addr = rx.addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign tx.be   = rx.be[grant_q*BW +: BW];
  assign tx.rd   = tx_rd_s;
  assign tx.wr   = tx_wr_s;

  assign rx.ardy = ardy_s;
  assign rx.drd  = tx.drd;
  assign rx.drdy = drdy_s;

  // One-hot handshake and response steering to the granted / head-of-FIFO master.
  always_comb begin
    ardy_s = {MASTERS{1'b0}};
    drdy_s = {MASTERS{1'b0}};
    if (busy_s && tx.ardy && !blocked_s) begin
      ardy_s[grant_q] = 1'b1;
    end else begin
      ardy_s = {MASTERS{1'b0}};
    end
    if (pop_s) begin
      drdy_s[head_s] = 1'b1;
    end else begin
      drdy_s = {MASTERS{1'b0}};
    end
  end

  // Next-state logic for the grant FSM and the outstanding-read ID FIFO.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    id_mem_d = id_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          grant_d = next_grant_s;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (accept_s) begin
          ptr_d   = grant_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (push_s) begin
      id_mem_d[wr_ptr_q] = grant_q;
      wr_ptr_d           = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; ptr resets to the last master so master 0 wins first.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      grant_q  <= {GW{1'b0}};
      ptr_q    <= GW'(MASTERS - 1);
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      cnt_q    <= {(PW+1){1'b0}};
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_mem_q[i] <= {GW{1'b0}};
      end
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      id_mem_q <= id_mem_d;
    end
  end
endmodule

// File: tb/tb_mi_arbiter_rr.sv
// Directed bench for mi_arbiter_rr with a transaction-level reference model
// compared every cycle, plus literal expectations for the key scenarios.
module tb_mi_arbiter_rr;
  localparam int M    = 4;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MW   = 2;
  localparam int BW   = DW / 8;
  localparam int MAXO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mi_arbiter_rr_if #(.N(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .META_WIDTH(MW)) rx_if ();
  mi_arbiter_rr_if #(.N(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .META_WIDTH(MW)) tx_if ();

  mi_arbiter_rr #(.MASTERS(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .META_WIDTH(MW),
                  .MAX_OUTSTANDING(MAXO)) dut (
    .CLK(clk), .RESET(rst), .rx(rx_if), .tx(tx_if));

  int n_cmp = 0;
  int n_err = 0;

  // master agents: outstanding request counts and the fields they present
  int          rd_left [M];
  int          wr_left [M];
  logic [AW-1:0] addr_v [M];
  logic [DW-1:0] dwr_v  [M];

  // reference model state
  int m_grant = -1;
  int m_last  = M - 1;
  int m_q[$];
  int glog[$];
  int acc_cnt [M];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < M; i++) begin
      rx_if.rd[i]               = (rd_left[i] > 0);
      rx_if.wr[i]               = (rd_left[i] == 0) && (wr_left[i] > 0);
      rx_if.addr[i*AW +: AW]    = addr_v[i];
      rx_if.dwr[i*DW +: DW]     = dwr_v[i];
      rx_if.mwr[i*MW +: MW]     = MW'(i);
      rx_if.be[i*BW +: BW]      = {BW{1'b1}};
    end
  endtask

  task automatic step();
    logic [M-1:0] ack;
    @(negedge clk);
    ack = rx_if.ardy;
    @(posedge clk);
    #1;
    for (int i = 0; i < M; i++) begin
      if (ack[i]) begin
        if (rd_left[i] > 0) rd_left[i]--;
        else if (wr_left[i] > 0) wr_left[i]--;
      end
    end
    drive();
  endtask

  task automatic clear_agents();
    for (int i = 0; i < M; i++) begin
      rd_left[i] = 0;
      wr_left[i] = 0;
      addr_v[i]  = 32'h1000 + 32'(i) * 32'h100;
      dwr_v[i]   = 32'hC0DE0000 + 32'(i);
      acc_cnt[i] = 0;
    end
    glog.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_agents();
    tx_if.drdy = 1'b0;
    drive();
    step();
    step();
    rst = 1'b0;
    glog.delete();
    for (int i = 0; i < M; i++) acc_cnt[i] = 0;
  endtask

  // Per-cycle compare against the model, then advance the model to the next edge.
  always @(negedge clk) begin
    logic [M-1:0] req, e_ardy, e_drdy;
    logic e_rd, e_wr, full;
    req    = rx_if.rd | rx_if.wr;
    full   = (m_q.size() == MAXO);
    e_rd   = 1'b0;
    e_wr   = 1'b0;
    e_ardy = '0;
    e_drdy = '0;
    if (m_grant >= 0) begin
      e_rd = rx_if.rd[m_grant] && !full;
      e_wr = rx_if.wr[m_grant];
      if (tx_if.ardy && !(rx_if.rd[m_grant] && full)) e_ardy[m_grant] = 1'b1;
    end
    if (tx_if.drdy && m_q.size() > 0) e_drdy[m_q[0]] = 1'b1;
    chk("tx_rd", 64'(tx_if.rd), 64'(e_rd));
    chk("tx_wr", 64'(tx_if.wr), 64'(e_wr));
    chk("rx_ardy", 64'(rx_if.ardy), 64'(e_ardy));
    chk("rx_drdy", 64'(rx_if.drdy), 64'(e_drdy));
    chk("rx_drd", 64'(rx_if.drd), 64'(tx_if.drd));
    if (e_rd || e_wr) begin
      chk("tx_addr", 64'(tx_if.addr), 64'(addr_v[m_grant]));
      chk("tx_dwr", 64'(tx_if.dwr), 64'(dwr_v[m_grant]));
      chk("tx_mwr", 64'(tx_if.mwr), 64'(m_grant));
      chk("tx_be", 64'(tx_if.be), 64'(4'hF));
    end
    if (tx_if.ardy && (tx_if.rd || tx_if.wr)) begin
      for (int i = 0; i < M; i++) begin
        if (rx_if.ardy[i]) begin
          glog.push_back(i);
          acc_cnt[i]++;
        end
      end
    end
    if (rst) begin
      m_grant = -1;
      m_last  = M - 1;
      m_q.delete();
    end else begin
      if (tx_if.drdy && m_q.size() > 0) void'(m_q.pop_front());
      if (m_grant >= 0) begin
        if (tx_if.ardy && (e_rd || e_wr)) begin
          if (e_rd) m_q.push_back(m_grant);
          m_last  = m_grant;
          m_grant = -1;
        end
      end else begin
        for (int k = 1; k <= M; k++) begin
          if (m_grant < 0 && req[(m_last + k) % M]) m_grant = (m_last + k) % M;
        end
      end
    end
  end

  int            exp_order [6] = '{0, 1, 3, 0, 1, 3};
  logic [DW-1:0] drd_tab   [3] = '{32'hA0, 32'hA1, 32'hA3};

  initial begin
    rst         = 1'b1;
    tx_if.ardy  = 1'b1;
    tx_if.drdy  = 1'b0;
    tx_if.drd   = 32'h0;
    clear_agents();
    drive();
    do_reset();
    #1;
    chk("reset_tx_rd", 64'(tx_if.rd), 64'(1'b0));
    chk("reset_rx_ardy", 64'(rx_if.ardy), 64'(4'b0000));

    // single write from master 2
    wr_left[2] = 1;
    addr_v[2]  = 32'h10;
    dwr_v[2]   = 32'hDEADBEEF;
    drive();
    #1;
    chk("wr_idle_tx_wr", 64'(tx_if.wr), 64'(1'b0));
    step(); #1;
    chk("wr_tx_wr", 64'(tx_if.wr), 64'(1'b1));
    chk("wr_tx_addr", 64'(tx_if.addr), 64'(32'h10));
    chk("wr_tx_dwr", 64'(tx_if.dwr), 64'(32'hDEADBEEF));
    chk("wr_rx_ardy", 64'(rx_if.ardy), 64'(4'b0100));
    step(); #1;
    chk("wr_ardy_pulse", 64'(rx_if.ardy), 64'(4'b0000));
    tx_if.drdy = 1'b1;
    tx_if.drd  = 32'h5;
    #1;
    chk("wr_no_push", 64'(rx_if.drdy), 64'(4'b0000));
    step();
    tx_if.drdy = 1'b0;

    // round robin among masters 0,1,3 with reads
    do_reset();
    rd_left[0] = 2; rd_left[1] = 2; rd_left[3] = 2;
    drive();
    repeat (14) step();
    #1;
    chk("rr_count", 64'(glog.size()), 64'(6));
    if (glog.size() == 6) begin
      for (int k = 0; k < 6; k++) chk("rr_order", 64'(glog[k]), 64'(exp_order[k]));
    end
    for (int k = 0; k < 6; k++) begin
      tx_if.drdy = 1'b1;
      tx_if.drd  = drd_tab[k % 3];
      #1;
      chk("rr_resp_drdy", 64'(rx_if.drdy), 64'(4'b1 << exp_order[k]));
      chk("rr_resp_drd", 64'(rx_if.drd), 64'(drd_tab[k % 3]));
      step();
    end
    tx_if.drdy = 1'b0;

    // master 1 issues 9 reads without responses
    do_reset();
    rd_left[1] = 9;
    drive();
    repeat (24) step();
    #1;
    chk("full_accepted", 64'(acc_cnt[1]), 64'(8));
    chk("full_tx_rd", 64'(tx_if.rd), 64'(1'b0));
    chk("full_rx_ardy", 64'(rx_if.ardy), 64'(4'b0000));
    tx_if.drdy = 1'b1;
    tx_if.drd  = 32'h11;
    #1;
    chk("full_pop_drdy", 64'(rx_if.drdy), 64'(4'b0010));
    chk("full_no_bypass", 64'(tx_if.rd), 64'(1'b0));
    step();
    tx_if.drdy = 1'b0;
    #1;
    chk("full_release_rd", 64'(tx_if.rd), 64'(1'b1));
    chk("full_release_ardy", 64'(rx_if.ardy), 64'(4'b0010));

    // write from master 0 while FIFO is full
    wr_left[0] = 1;
    addr_v[0]  = 32'h40;
    drive();
    step();
    step(); #1;
    chk("full_wr_tx_wr", 64'(tx_if.wr), 64'(1'b1));
    chk("full_wr_ardy", 64'(rx_if.ardy), 64'(4'b0001));
    chk("full_wr_addr", 64'(tx_if.addr), 64'(32'h40));
    step();
    for (int k = 0; k < 8; k++) begin
      tx_if.drdy = 1'b1;
      #1;
      chk("drain_drdy", 64'(rx_if.drdy), 64'(4'b0010));
      step();
    end
    tx_if.drdy = 1'b0;

    // push and pop in the same cycle with 7 outstanding
    do_reset();
    rd_left[2] = 7;
    drive();
    repeat (20) step();
    rd_left[3] = 1;
    drive();
    step();
    tx_if.drdy = 1'b1;
    tx_if.drd  = 32'h77;
    #1;
    chk("pp_tx_rd", 64'(tx_if.rd), 64'(1'b1));
    chk("pp_ardy", 64'(rx_if.ardy), 64'(4'b1000));
    chk("pp_drdy", 64'(rx_if.drdy), 64'(4'b0100));
    step();
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("pp_drain", 64'(rx_if.drdy), 64'((k < 6) ? 4'b0100 : 4'b1000));
      step();
    end
    #1;
    chk("pp_empty", 64'(rx_if.drdy), 64'(4'b0000));
    step();
    tx_if.drdy = 1'b0;

    // reset with reads outstanding
    do_reset();
    rd_left[1] = 3;
    drive();
    repeat (10) step();
    rst = 1'b1;
    clear_agents();
    drive();
    step();
    rst = 1'b0;
    tx_if.drdy = 1'b1;
    tx_if.drd  = 32'h99;
    #1;
    chk("rst_stale_drdy", 64'(rx_if.drdy), 64'(4'b0000));
    tx_if.drdy = 1'b0;
    wr_left[0] = 1; wr_left[1] = 1; wr_left[2] = 1;
    drive();
    step(); #1;
    chk("rst_first_grant", 64'(rx_if.ardy), 64'(4'b0001));
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
